gpsreceiver2_capctl: RTL
========================

Name: gpsreceiver2_capctl

Overview:
Capture sequencer for the GPS-SDR sample path, in the sys_clk domain. It takes packed sample bytes, already retimed into sys_clk, and runs the write port of the 2048-byte capture RAM as a ping-pong buffer of two halves. It hands completed halves to software through ownership flags and an interrupt. Sample bytes that arrive while software still owns the next half are dropped and counted.

Parameters:
adr_width, 11, capture RAM byte-address width; each half holds 2^(adr_width-1) bytes.
ovr_width, 16, width of the saturating dropped-byte counter.

Ports:
sys_clk  in  1  system clock.
sys_rst  in  1  synchronous reset, active-high.
cfg_start  in  1  one-cycle pulse: arm and begin capture at address 0.
cfg_stop  in  1  one-cycle pulse: abort capture.
cfg_continuous  in  1  1 = loop over both halves forever; 0 = one-shot, fill both halves once.
buf_ack  in  2  one-cycle pulses: bit h returns half h to hardware.
smp_stb  in  1  sample byte valid, one cycle.
smp_dat  in  8  sample byte.
mem_adr  out  adr_width  RAM write address.
mem_dat  out  8  RAM write data.
mem_we  out  1  RAM write enable.
half_full  out  2  bit h = half h is complete and owned by software.
busy  out  1  capture armed (state RUN or WAIT).
overrun  out  1  sticky flag: at least one byte dropped.
ovr_count  out  ovr_width  saturating count of dropped bytes.
irq  out  1  one-cycle pulse when a half completes.

Behaviour:
- Reset (sys_rst=1 at an edge) forces all outputs and internal state to 0. State becomes IDLE, write pointer wptr=0.
- States:
  - IDLE: smp_stb ignored; no write, no drop count.
  - RUN: smp_stb accepted. Next cycle: mem_we=1, mem_adr=wptr at acceptance, mem_dat=byte. Write latency is exactly 1 cycle. wptr increments, wrapping 2047 to 0.
  - Completing a half: accepting the byte at the last address of half h (wptr[adr_width-2:0] all ones):
    - half_full[h] set and irq pulses in the same cycle as that byte's mem_we.
    - One-shot mode and h=1: go to DONE.
    - Otherwise, if half_full[other half] is already 1: go to WAIT.
    - Otherwise stay in RUN.
  - WAIT: every smp_stb is dropped. overrun is set; ovr_count increments and saturates at all ones. wptr is held at the first address of the blocked half. When buf_ack clears that half's flag, the state is RUN from the next cycle. A byte arriving in the same cycle as the ack is still dropped.
  - DONE: busy=0; smp_stb ignored and not counted. half_full holds until acked.
- busy = (state==RUN or WAIT).
- buf_ack[h] clears half_full[h]. If the set and the ack of the same half fall in the same cycle, the set wins.
- cfg_start from any state:
  - clears half_full, overrun, ovr_count and wptr; enters RUN.
  - a write already in flight still completes on mem_we.
- cfg_stop from any state: enters IDLE. half_full, overrun and ovr_count are held. An in-flight write completes. If start and stop coincide, stop wins.
- smp_stb coinciding with cfg_start: byte dropped, not counted.
- smp_stb coinciding with cfg_stop: byte not written.
- cfg_continuous is sampled at every half completion, so a mode change takes effect at the next boundary.
- mem_we is never asserted for two different addresses in the same cycle. Back-to-back smp_stb every cycle is sustained in RUN with no loss.

Test Plan:
- Reset then start, 1024 bytes 0x00..0xFF repeating, one every 4 cycles:
  - mem_adr 0..1023, each write 1 cycle after its strobe;
  - half_full=01 and a single irq pulse coincident with the write to adr 1023;
  - busy=1.
- One-shot, 2048 back-to-back bytes:
  - half_full=11, 2 irq pulses, state DONE, busy=0;
  - a further 10 strobes produce no writes and leave ovr_count=0.
- Continuous, 2048 bytes with no ack, then 5 more strobes:
  - state WAIT, overrun=1, ovr_count=5, no writes.
  - Then pulse buf_ack=01 with a strobe in the same cycle: that byte is dropped (ovr_count=6). The next strobe writes adr 0.
- Completion and ack collide: buf_ack[0] pulsed in the exact cycle half 0 completes -> half_full[0] stays 1.
- cfg_stop in mid-capture at wptr=300 with a strobe in the same cycle:
  - no write for that byte; an earlier in-flight write completes;
  - busy=0; flags held.
  - Then cfg_start -> flags and counters clear, next write at adr 0.
- Force ovr_count to all ones minus 1 (ovr_width=4 build), then drop 3 bytes -> ovr_count=4'hF, stays saturated.
- Assert sys_rst during WAIT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/gpsreceiver2_capctl.sv
// Capture sequencer for the GPS-SDR sample path: drives the capture RAM write port as a
// ping-pong buffer of two halves and hands completed halves to software via flags and irq.
module gpsreceiver2_capctl #(
    parameter int adr_width = 11,
    parameter int ovr_width = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_continuous,
    input  logic [1:0]           buf_ack,
    input  logic                 smp_stb,
    input  logic [7:0]           smp_dat,
    output logic [adr_width-1:0] mem_adr,
    output logic [7:0]           mem_dat,
    output logic                 mem_we,
    output logic [1:0]           half_full,
    output logic                 busy,
    output logic                 overrun,
    output logic [ovr_width-1:0] ovr_count,
    output logic                 irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [adr_width-1:0] WPTR_ONE = {{(adr_width-1){1'b0}}, 1'b1};
    localparam logic [ovr_width-1:0] OVR_ONE  = {{(ovr_width-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic [adr_width-1:0] wptr_q;
    logic [adr_width-1:0] mem_adr_q;
    logic [7:0]           mem_dat_q;
    logic                 mem_we_q;
    logic [1:0]           half_full_q;
    logic                 overrun_q;
    logic [ovr_width-1:0] ovr_count_q;
    logic                 irq_q;

    logic cur_half;
    logic other_half;
    logic half_last;

    // Write-pointer decode: which half is being filled, and whether this is its last byte.
    // In WAIT the pointer sits on the first byte of the blocked half, so cur_half names it.
    always_comb begin
        cur_half   = wptr_q[adr_width-1];
        other_half = ~wptr_q[adr_width-1];
        half_last  = &wptr_q[adr_width-2:0];
    end

    // Sequencer state, write port, ownership flags and drop accounting.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            mem_adr_q   <= '0;
            mem_dat_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            half_full_q <= 2'b00;
            overrun_q   <= 1'b0;
            ovr_count_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            irq_q       <= 1'b0;
            half_full_q <= half_full_q & ~buf_ack;
            if (cfg_stop) begin
                state_q <= ST_IDLE;
            end else if (cfg_start) begin
                state_q     <= ST_RUN;
                wptr_q      <= '0;
                half_full_q <= 2'b00;
                overrun_q   <= 1'b0;
                ovr_count_q <= '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (smp_stb) begin
                            mem_we_q  <= 1'b1;
                            mem_adr_q <= wptr_q;
                            mem_dat_q <= smp_dat;
                            wptr_q    <= wptr_q + WPTR_ONE;
                            if (half_last) begin
                                // A completion beats an ack of the same half in this cycle.
                                half_full_q[cur_half] <= 1'b1;
                                irq_q                 <= 1'b1;
                                if (!cfg_continuous && cur_half) begin
                                    state_q <= ST_DONE;
                                end else if (half_full_q[other_half] && !buf_ack[other_half]) begin
                                    state_q <= ST_WAIT;
                                end else begin
                                    state_q <= ST_RUN;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (smp_stb) begin
                            overrun_q <= 1'b1;
                            if (!(&ovr_count_q)) begin
                                ovr_count_q <= ovr_count_q + OVR_ONE;
                            end
                        end
                        if (buf_ack[cur_half]) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign mem_adr   = mem_adr_q;
    assign mem_dat   = mem_dat_q;
    assign mem_we    = mem_we_q;
    assign half_full = half_full_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign overrun   = overrun_q;
    assign ovr_count = ovr_count_q;
    assign irq       = irq_q;

endmodule
